// File: rtl/pipe_e_reg_ctrl_pkg.sv
// Shared constants and types for the Y86-64 decode->execute pipeline register.
// Holds status codes, icodes, the "no register" id, the E-stage payload struct,
// and helpers used by the E register and the hazard decode.
package pipe_e_reg_ctrl_pkg;

    localparam int unsigned STAT_W  = 3;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned VAL_W   = 64;

    // Status codes
    localparam logic [STAT_W-1:0] SBUB = 3'd0;
    localparam logic [STAT_W-1:0] SAOK = 3'd1;
    localparam logic [STAT_W-1:0] SHLT = 3'd2;
    localparam logic [STAT_W-1:0] SADR = 3'd3;
    localparam logic [STAT_W-1:0] SINS = 3'd4;

    // Instruction codes
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [REG_W-1:0] REG_NONE = 4'hF;

    // Decode->execute payload
    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic [ICODE_W-1:0] ifun;
        logic [VAL_W-1:0]   val_c;
        logic [VAL_W-1:0]   val_a;
        logic [VAL_W-1:0]   val_b;
        logic [REG_W-1:0]   dst_e;
        logic [REG_W-1:0]   dst_m;
        logic [REG_W-1:0]   src_a;
        logic [REG_W-1:0]   src_b;
    } e_fields_t;

    // Contents loaded into E for a bubble (and at reset)
    function automatic e_fields_t bubble_fields(logic [REG_W-1:0] rnone,
                                                logic [ICODE_W-1:0] nop_icode);
        e_fields_t f;
        f.stat  = SBUB;
        f.icode = nop_icode;
        f.ifun  = '0;
        f.val_c = '0;
        f.val_a = '0;
        f.val_b = '0;
        f.dst_e = rnone;
        f.dst_m = rnone;
        f.src_a = rnone;
        f.src_b = rnone;
        return f;
    endfunction

    // Exceptional status downstream blocks condition-code updates
    function automatic logic stat_is_exc(logic [STAT_W-1:0] s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction

endpackage

// File: rtl/pipe_e_reg_ctrl_if.sv
// Bundle of decode-side inputs, downstream status inputs and E-stage / control
// outputs of the decode->execute register.
//   master: drives D/d fields, e_cnd, M_icode, m_stat, W_stat; observes E_* and controls
//   slave : the E register block
interface pipe_e_reg_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [2:0]       D_stat;
    logic [3:0]       D_icode;
    logic [3:0]       D_ifun;
    logic [63:0]      d_valC;
    logic [63:0]      d_valA;
    logic [63:0]      d_valB;
    logic [3:0]       d_dstE;
    logic [3:0]       d_dstM;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic             e_cnd;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;

    logic [2:0]       E_stat;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [63:0]      E_valC;
    logic [63:0]      E_valA;
    logic [63:0]      E_valB;
    logic [3:0]       E_dstE;
    logic [3:0]       E_dstM;
    logic [3:0]       E_srcA;
    logic [3:0]       E_srcB;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             cc_en;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output D_stat, D_icode, D_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, e_cnd, M_icode, m_stat, W_stat,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB,
               F_stall, D_stall, D_bubble, cc_en, bubble_cnt
    );

    modport slave (
        input  D_stat, D_icode, D_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, e_cnd, M_icode, m_stat, W_stat,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_dstE, E_dstM, E_srcA, E_srcB,
               F_stall, D_stall, D_bubble, cc_en, bubble_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Combinational hazard decode for the decode->execute boundary.
// Inputs : D_icode, current E icode/dstM, d_srcA/d_srcB, e_cnd, M_icode, m_stat, W_stat
// Outputs: e_bubble, f_stall, d_stall, d_bubble, cc_en (all combinational)
module pipe_hazard_ctrl
    import pipe_e_reg_ctrl_pkg::*;
#(
    parameter logic [3:0] RNONE = REG_NONE
) (
    input  logic [3:0] d_icode,
    input  logic [3:0] e_icode,
    input  logic [3:0] e_dst_m,
    input  logic [3:0] d_src_a,
    input  logic [3:0] d_src_b,
    input  logic       e_cnd,
    input  logic [3:0] m_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] w_stat,
    output logic       e_bubble,
    output logic       f_stall,
    output logic       d_stall,
    output logic       d_bubble,
    output logic       cc_en
);

    logic load_use;
    logic mispredict;
    logic ret_pending;

    // Hazard detection
    always_comb begin
        load_use    = 1'b0;
        mispredict  = 1'b0;
        ret_pending = 1'b0;

        if (((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) &&
            (e_dst_m != RNONE) &&
            ((e_dst_m == d_src_a) || (e_dst_m == d_src_b))) begin
            load_use = 1'b1;
        end

        mispredict  = (e_icode == I_JXX) && !e_cnd;
        ret_pending = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
    end

    // Pipeline control; load/use stalls D rather than bubbling it
    always_comb begin
        e_bubble = 1'b0;
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        cc_en    = 1'b0;

        e_bubble = load_use || mispredict;
        f_stall  = load_use || ret_pending;
        d_stall  = load_use;
        d_bubble = mispredict || (ret_pending && !load_use);
        cc_en    = (e_icode == I_OPQ) && !stat_is_exc(m_stat) && !stat_is_exc(w_stat);
    end

endmodule

// File: rtl/pipe_e_reg_ctrl.sv
// Decode->execute pipeline register with hazard control and a saturating
// E-bubble counter.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport carrying the
// D/d inputs, downstream status, E_* outputs, stall/bubble controls, cc_en and
// bubble_cnt).
module pipe_e_reg_ctrl
    import pipe_e_reg_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter logic [3:0]  RNONE     = REG_NONE,
    parameter logic [3:0]  NOP_ICODE = I_NOP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipe_e_reg_ctrl_if.slave         bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    e_fields_t        e_q;
    e_fields_t        d_fields;
    e_fields_t        bub_fields;
    logic [CNT_W-1:0] cnt_q;
    logic             e_bubble;

    assign bub_fields = bubble_fields(RNONE, NOP_ICODE);

    // Gather decode-stage fields into the payload
    always_comb begin
        d_fields       = '0;
        d_fields.stat  = bus.D_stat;
        d_fields.icode = bus.D_icode;
        d_fields.ifun  = bus.D_ifun;
        d_fields.val_c = bus.d_valC;
        d_fields.val_a = bus.d_valA;
        d_fields.val_b = bus.d_valB;
        d_fields.dst_e = bus.d_dstE;
        d_fields.dst_m = bus.d_dstM;
        d_fields.src_a = bus.d_srcA;
        d_fields.src_b = bus.d_srcB;
    end

    pipe_hazard_ctrl #(
        .RNONE (RNONE)
    ) u_hazard (
        .d_icode  (bus.D_icode),
        .e_icode  (e_q.icode),
        .e_dst_m  (e_q.dst_m),
        .d_src_a  (bus.d_srcA),
        .d_src_b  (bus.d_srcB),
        .e_cnd    (bus.e_cnd),
        .m_icode  (bus.M_icode),
        .m_stat   (bus.m_stat),
        .w_stat   (bus.W_stat),
        .e_bubble (e_bubble),
        .f_stall  (bus.F_stall),
        .d_stall  (bus.D_stall),
        .d_bubble (bus.D_bubble),
        .cc_en    (bus.cc_en)
    );

    // E register never stalls: it either loads D or a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q   <= bub_fields;
            cnt_q <= '0;
        end else begin
            e_q <= e_bubble ? bub_fields : d_fields;
            if (e_bubble && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.E_stat     = e_q.stat;
    assign bus.E_icode    = e_q.icode;
    assign bus.E_ifun     = e_q.ifun;
    assign bus.E_valC     = e_q.val_c;
    assign bus.E_valA     = e_q.val_a;
    assign bus.E_valB     = e_q.val_b;
    assign bus.E_dstE     = e_q.dst_e;
    assign bus.E_dstM     = e_q.dst_m;
    assign bus.E_srcA     = e_q.src_a;
    assign bus.E_srcB     = e_q.src_b;
    assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_e_reg_ctrl.sv
// Directed bench for the decode->execute register; a narrow counter makes
// saturation reachable in a short run.
module tb_pipe_e_reg_ctrl;

    localparam int unsigned CW = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   exp_cnt;

    pipe_e_reg_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_e_reg_ctrl #(
        .CNT_W     (CW),
        .RNONE     (4'hF),
        .NOP_ICODE (4'h1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [3:0] dste, input logic [3:0] dstm,
                         input logic [3:0] srca, input logic [3:0] srcb);
        bus.D_icode = icode;
        bus.D_ifun  = ifun;
        bus.d_dstE  = dste;
        bus.d_dstM  = dstm;
        bus.d_srcA  = srca;
        bus.d_srcB  = srcb;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;

        // Reset with arbitrary D contents
        rst_n       = 1'b0;
        bus.D_stat  = 3'd1;
        bus.d_valC  = 64'hDEAD;
        bus.d_valA  = 64'hAA;
        bus.d_valB  = 64'hBB;
        bus.e_cnd   = 1'b1;
        bus.M_icode = 4'h1;
        bus.m_stat  = 3'd1;
        bus.W_stat  = 3'd1;
        set_d(4'h6, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
        tick();
        tick();
        chk("rst_E_icode", 64'(bus.E_icode), 64'h1);
        chk("rst_E_stat", 64'(bus.E_stat), 64'h0);
        chk("rst_E_dstE", 64'(bus.E_dstE), 64'hF);
        chk("rst_E_srcA", 64'(bus.E_srcA), 64'hF);
        chk("rst_E_valA", bus.E_valA, 64'h0);
        chk("rst_cnt", 64'(bus.bubble_cnt), 64'h0);

        // Pass-through
        rst_n      = 1'b1;
        bus.d_valC = 64'h11;
        bus.d_valA = 64'h5;
        bus.d_valB = 64'h7;
        set_d(4'h6, 4'h0, 4'h3, 4'hF, 4'h1, 4'h3);
        #1;
        chk("pt_F_stall", 64'(bus.F_stall), 64'h0);
        chk("pt_D_stall", 64'(bus.D_stall), 64'h0);
        chk("pt_D_bubble", 64'(bus.D_bubble), 64'h0);
        chk("pt_cc_en_nop", 64'(bus.cc_en), 64'h0);
        tick();
        chk("pt_E_icode", 64'(bus.E_icode), 64'h6);
        chk("pt_E_stat", 64'(bus.E_stat), 64'h1);
        chk("pt_E_valA", bus.E_valA, 64'h5);
        chk("pt_E_valB", bus.E_valB, 64'h7);
        chk("pt_E_valC", bus.E_valC, 64'h11);
        chk("pt_E_dstE", 64'(bus.E_dstE), 64'h3);

        // cc_en gating with E_icode=OPQ
        chk("cc_ok", 64'(bus.cc_en), 64'h1);
        bus.m_stat = 3'd3; #1;
        chk("cc_m_sadr", 64'(bus.cc_en), 64'h0);
        bus.m_stat = 3'd1; bus.W_stat = 3'd2; #1;
        chk("cc_w_shlt", 64'(bus.cc_en), 64'h0);
        bus.m_stat = 3'd0; bus.W_stat = 3'd0; #1;
        chk("cc_sbub", 64'(bus.cc_en), 64'h1);
        bus.W_stat = 3'd4; #1;
        chk("cc_w_sins", 64'(bus.cc_en), 64'h0);
        bus.m_stat = 3'd1; bus.W_stat = 3'd1;

        // Load/use on srcB from MRMOVQ
        set_d(4'h5, 4'h0, 4'hF, 4'h2, 4'hF, 4'h4);
        tick();
        chk("lu_E_dstM", 64'(bus.E_dstM), 64'h2);
        set_d(4'h6, 4'h0, 4'h3, 4'hF, 4'h1, 4'h2);
        #1;
        chk("lu_F_stall", 64'(bus.F_stall), 64'h1);
        chk("lu_D_stall", 64'(bus.D_stall), 64'h1);
        chk("lu_D_bubble", 64'(bus.D_bubble), 64'h0);
        tick();
        exp_cnt = 1;
        chk("lu_E_icode", 64'(bus.E_icode), 64'h1);
        chk("lu_E_dstM", 64'(bus.E_dstM), 64'hF);
        chk("lu_E_stat", 64'(bus.E_stat), 64'h0);
        chk("lu_cnt", 64'(bus.bubble_cnt), 64'(exp_cnt));
        chk("lu_clear", 64'(bus.F_stall), 64'h0);

        // Load/use on srcA from POPQ
        set_d(4'hB, 4'h0, 4'h4, 4'h5, 4'h4, 4'h4);
        tick();
        set_d(4'h6, 4'h0, 4'h3, 4'hF, 4'h5, 4'hF);
        #1;
        chk("pop_D_stall", 64'(bus.D_stall), 64'h1);
        tick();
        exp_cnt = 2;
        chk("pop_cnt", 64'(bus.bubble_cnt), 64'(exp_cnt));

        // dstM = RNONE never triggers load/use
        set_d(4'hB, 4'h0, 4'h4, 4'hF, 4'hF, 4'hF);
        tick();
        set_d(4'h6, 4'h0, 4'h3, 4'hF, 4'hF, 4'hF);
        #1;
        chk("rnone_D_stall", 64'(bus.D_stall), 64'h0);
        tick();
        chk("rnone_E_icode", 64'(bus.E_icode), 64'h6);
        chk("rnone_cnt", 64'(bus.bubble_cnt), 64'(exp_cnt));

        // Load/use takes precedence over a RET in D
        set_d(4'h5, 4'h0, 4'hF, 4'h2, 4'hF, 4'h4);
        tick();
        set_d(4'h9, 4'h0, 4'hF, 4'hF, 4'hF, 4'h2);
        #1;
        chk("prec_F_stall", 64'(bus.F_stall), 64'h1);
        chk("prec_D_stall", 64'(bus.D_stall), 64'h1);
        chk("prec_D_bubble", 64'(bus.D_bubble), 64'h0);
        tick();
        exp_cnt = 3;
        chk("prec_cnt", 64'(bus.bubble_cnt), 64'(exp_cnt));

        // RET moving D -> E -> M
        chk("ret1_F_stall", 64'(bus.F_stall), 64'h1);
        chk("ret1_D_bubble", 64'(bus.D_bubble), 64'h1);
        chk("ret1_D_stall", 64'(bus.D_stall), 64'h0);
        tick();
        chk("ret2_E_icode", 64'(bus.E_icode), 64'h9);
        set_d(4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        #1;
        chk("ret2_F_stall", 64'(bus.F_stall), 64'h1);
        chk("ret2_D_bubble", 64'(bus.D_bubble), 64'h1);
        tick();
        bus.M_icode = 4'h9; #1;
        chk("ret3_F_stall", 64'(bus.F_stall), 64'h1);
        chk("ret3_D_bubble", 64'(bus.D_bubble), 64'h1);
        bus.M_icode = 4'h1; #1;
        chk("ret_done_F_stall", 64'(bus.F_stall), 64'h0);
        chk("ret_done_D_bubble", 64'(bus.D_bubble), 64'h0);

        // Mispredicted jump
        set_d(4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        set_d(4'h6, 4'h0, 4'h3, 4'hF, 4'h1, 4'h2);
        bus.e_cnd = 1'b0; #1;
        chk("mp_D_bubble", 64'(bus.D_bubble), 64'h1);
        chk("mp_F_stall", 64'(bus.F_stall), 64'h0);
        chk("mp_D_stall", 64'(bus.D_stall), 64'h0);
        tick();
        exp_cnt = 4;
        chk("mp_E_icode", 64'(bus.E_icode), 64'h1);
        chk("mp_E_ifun", 64'(bus.E_ifun), 64'h0);
        chk("mp_cnt", 64'(bus.bubble_cnt), 64'(exp_cnt));

        // Taken jump: no bubble
        bus.e_cnd = 1'b1;
        set_d(4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF);
        tick();
        set_d(4'h6, 4'h0, 4'h3, 4'hF, 4'h1, 4'h2);
        #1;
        chk("tk_D_bubble", 64'(bus.D_bubble), 64'h0);
        tick();
        chk("tk_E_icode", 64'(bus.E_icode), 64'h6);
        chk("tk_cnt", 64'(bus.bubble_cnt), 64'(exp_cnt));

        // Repeated mispredicts drive the counter into saturation
        bus.e_cnd = 1'b0;
        set_d(4'h7, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        for (int i = 0; i < 16; i++) begin
            tick();
            tick();
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            chk("sat_cnt", 64'(bus.bubble_cnt), 64'(exp_cnt));
        end
        chk("sat_final", 64'(bus.bubble_cnt), 64'hF);

        // Reset in the middle of a load/use stall
        bus.e_cnd = 1'b1;
        set_d(4'h5, 4'h0, 4'hF, 4'h2, 4'hF, 4'h4);
        tick();
        set_d(4'h6, 4'h0, 4'h3, 4'hF, 4'h2, 4'hF);
        #1;
        chk("rlu_D_stall", 64'(bus.D_stall), 64'h1);
        rst_n = 1'b0;
        tick();
        chk("rlu_E_icode", 64'(bus.E_icode), 64'h1);
        chk("rlu_E_dstM", 64'(bus.E_dstM), 64'hF);
        chk("rlu_cnt", 64'(bus.bubble_cnt), 64'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_E_icode", 64'(bus.E_icode), 64'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_e_reg_ctrl.md
Name: pipe_e_reg_ctrl

Overview:
- Decode→execute pipeline register for the Y86-64 pipe: latches decode-stage fields and drives every E_* signal consumed by the execute stage.
- Owns the hazard-control logic that decides when E is loaded normally or injected with a bubble: load/use hazard and mispredicted conditional jump.
- Drives the F/D stall and bubble controls and the condition-code write enable used by the execute stage.
- Keeps a saturating count of E-bubbles inserted, for performance debug.

Parameters:
- CNT_W, 32, width of bubble performance counter
- RNONE, 4'hF, "no register" id
- NOP_ICODE, 4'h1, icode loaded on bubble

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- D_stat  in  3  decode-stage status
- D_icode  in  4  decode-stage icode
- D_ifun  in  4  decode-stage ifun
- d_valC  in  64  decoded constant
- d_valA  in  64  forwarded valA
- d_valB  in  64  forwarded valB
- d_dstE  in  4  E destination register
- d_dstM  in  4  M destination register
- d_srcA  in  4  source A register
- d_srcB  in  4  source B register
- e_cnd  in  1  branch/cmov condition from execute
- M_icode  in  4  memory-stage icode
- m_stat  in  3  memory-stage status
- W_stat  in  3  write-back-stage status
- E_stat  out  3  registered status
- E_icode  out  4  registered icode
- E_ifun  out  4  registered ifun
- E_valC  out  64  registered constant
- E_valA  out  64  registered valA
- E_valB  out  64  registered valB
- E_dstE  out  4  registered destination E
- E_dstM  out  4  registered destination M
- E_srcA  out  4  registered source A
- E_srcB  out  4  registered source B
- F_stall  out  1  hold fetch PC
- D_stall  out  1  hold D register
- D_bubble  out  1  bubble D register
- cc_en  out  1  condition-code write permitted
- bubble_cnt  out  CNT_W  number of E bubbles inserted

Behaviour:
- Status codes (shared): SBUB=0, SAOK=1, SHLT=2, SADR=3, SINS=4. Icodes: JXX=7, MRMOVQ=5, POPQ=B, RET=9, OPQ=6.
- Reset: when rst_n=0 at a clk edge, E_* is loaded with the bubble value and bubble_cnt=0.
  - Bubble value: stat=SBUB, icode=NOP_ICODE, ifun=0, valC/valA/valB=0, dstE/dstM/srcA/srcB=RNONE.
  - Reset has priority over all other behaviour, including in the middle of a stall or bubble.
- load_use (combinational) is true when all of the following hold:
  - E_icode is MRMOVQ or POPQ;
  - E_dstM != RNONE;
  - E_dstM equals d_srcA or d_srcB.
- mispredict (combinational) = (E_icode==JXX) && !e_cnd.
- ret_pending (combinational) = RET present in D_icode, E_icode or M_icode.
- E_bubble = load_use || mispredict.
  - On an E_bubble edge, E loads the bubble value.
  - Otherwise E loads the D/d inputs unmodified. Latency: 1 cycle.
- F_stall = load_use || ret_pending.
- D_stall = load_use.
- D_bubble = mispredict || (ret_pending && !load_use). Load/use takes precedence: D_stall=1 and D_bubble=0.
- The E register never stalls.
- cc_en = (E_icode==OPQ), with two gates:
  - forced 0 if m_stat is SHLT/SADR/SINS;
  - forced 0 if W_stat is SHLT/SADR/SINS.
  - SBUB and SAOK do not block.
- bubble_cnt increments by 1 on each edge where E_bubble=1 and rst_n=1.
  - load_use and mispredict together still count +1.
  - Saturates at all-ones and does not wrap.
- Control outputs are combinational from current E_*, M_icode, D/d and stat inputs. They have no reset value beyond what follows from the reset contents of E.

Decomposition:
- Shared package holds: status codes, icode constants (NOP, JXX, MRMOVQ, POPQ, RET, OPQ), RNONE, and the bubble-value constants.
- One natural sub-module, pipe_hazard_ctrl: purely combinational load_use/mispredict/ret and stall/bubble/cc_en decode.
- pipe_e_reg_ctrl instantiates pipe_hazard_ctrl and holds the E flops and the counter.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with arbitrary D inputs → E_icode=1, E_stat=0, E_dstE=F, E_valA=0, bubble_cnt=0.
- Pass-through: D_icode=6, d_valA=5, d_valB=7, d_dstE=3, E_icode=6 → next edge E_icode=6, E_valA=5, E_valB=7, E_dstE=3; no stall or bubble.
- Load/use: E_icode=5, E_dstM=2, d_srcB=2 → F_stall=1, D_stall=1, D_bubble=0; next edge E_icode=1, bubble_cnt +1.
- Mispredict: E_icode=7, e_cnd=0 → D_bubble=1, F_stall=0; next edge E is the bubble. With e_cnd=1 → no bubble.
- Ret and counter saturation:
  - D_icode=9 → F_stall=1, D_bubble=1 for 3 cycles as RET moves D→E→M.
  - Preload bubble_cnt to all-ones, force a bubble → bubble_cnt stays all-ones.
- cc_en gating:
  - E_icode=6, m_stat=1, W_stat=1 → cc_en=1.
  - m_stat=3 → cc_en=0; W_stat=2 → cc_en=0.
  - Reset asserted mid load/use stall → E bubble, bubble_cnt=0 on the next edge.
